// File: rtl/blowfish128_round_ctrl.sv
// -----------------------------------------------------------------------------
// blowfish128_round_ctrl
//
// Round sequencer for the Blowfish-128 cipher core. One 128-bit block {L,R} is
// walked through 16 Feistel rounds and a final whitening step. Each round
// applies one P-array subkey to L (read through an external combinational
// port) and then calls the shared F-function through its Enable/outputValid
// handshake. One controller owns one F-function instance.
//
// Parameters
//   TIMEOUT_CYCLES  watchdog limit per F-function call, in cycles. It only has
//                   an effect when BLOWFISH128_ROUND_TIMEOUT_EN is defined.
//
// Compile-time option
//   BLOWFISH128_ROUND_TIMEOUT_EN  builds the per-call watchdog. An F call that
//                   has not returned FValid after TIMEOUT_CYCLES FCALL cycles
//                   raises Error for one cycle and drops back to IDLE.
//                   Undefined (default): no counter, Error tied to 0, FCALL
//                   waits indefinitely.
//
// Ports
//   Clk       in   1    clock, rising edge
//   RstN      in   1    asynchronous active-low reset
//   Start     in   1    process BlockIn; sampled only in IDLE
//   Decrypt   in   1    0 = encrypt, 1 = decrypt; sampled with Start
//   BlockIn   in   128  input block, [127:64] = L, [63:0] = R
//   PIdx      out  5    P-array read index (0..17), from registered state only
//   PSub      in   64   P-array entry at PIdx, valid in the same cycle
//   FEnable   out  1    F-function Enable; its low level resets the F-function
//   FX        out  64   F-function input X
//   FY        in   64   F-function output Y
//   FValid    in   1    F-function outputValid; ignored outside FCALL
//   BlockOut  out  128  result {L,R}; holds until the next Done
//   Done      out  1    one-cycle pulse; BlockOut carries the new value with it
//   Busy      out  1    high in every state except IDLE
//   Error     out  1    one-cycle watchdog abort pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module blowfish128_round_ctrl #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         Start,
  input  logic         Decrypt,
  input  logic [127:0] BlockIn,
  output logic [4:0]   PIdx,
  input  logic [63:0]  PSub,
  output logic         FEnable,
  output logic [63:0]  FX,
  input  logic [63:0]  FY,
  input  logic         FValid,
  output logic [127:0] BlockOut,
  output logic         Done,
  output logic         Busy,
  output logic         Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,    // L ^= P[idx(rnd)], F-function held in reset
    S_FCALL,  // F-function running on X = L
    S_WHT_R,  // R ^= P[idx(16)]
    S_WHT_L,  // L ^= P[idx(17)], result captured
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [63:0]  l_q, r_q;
  logic [3:0]   rnd_q;
  logic         dec_q;
  logic [127:0] block_out_q;
  logic         timeout;

  // Subkey index for step k: k when encrypting, 17-k when decrypting.
  function automatic logic [4:0] sub_idx(input logic dec, input logic [4:0] k);
    return dec ? (5'd17 - k) : k;
  endfunction

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef BLOWFISH128_ROUND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Counts FCALL cycles already spent without an answer. Every FCALL is
  // entered from KEY, so clearing in KEY is the same as clearing on entry.
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      tmo_q <= '0;
    end else if (state_q == S_KEY) begin
      tmo_q <= '0;
    end else if (state_q == S_FCALL && tmo_q != TMO_LAST) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th FCALL cycle if FValid is still low; an
  // answer arriving in that very cycle still wins.
  assign timeout = (state_q == S_FCALL) && !FValid && (tmo_q == TMO_LAST);
`else
  // The limit has no effect without the watchdog; FCALL waits indefinitely.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (Start) state_d = S_KEY;
      S_KEY:   state_d = S_FCALL;
      S_FCALL: begin
        if (FValid) begin
          state_d = (rnd_q == 4'd15) ? S_WHT_R : S_KEY;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_WHT_R: state_d = S_WHT_L;
      S_WHT_L: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      l_q         <= '0;
      r_q         <= '0;
      rnd_q       <= '0;
      dec_q       <= 1'b0;
      block_out_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            l_q   <= BlockIn[127:64];
            r_q   <= BlockIn[63:0];
            dec_q <= Decrypt;
            rnd_q <= '0;
          end
        end
        S_KEY: begin
          l_q <= l_q ^ PSub;
        end
        S_FCALL: begin
          if (FValid) begin
            if (rnd_q != 4'd15) begin
              // Feistel step and half swap in one update.
              l_q   <= r_q ^ FY;
              r_q   <= l_q;
              rnd_q <= rnd_q + 4'd1;
            end else begin
              // Last round leaves the halves in place.
              r_q <= r_q ^ FY;
            end
          end
        end
        S_WHT_R: begin
          r_q <= r_q ^ PSub;
        end
        S_WHT_L: begin
          // The output register is loaded on the edge into DONE so that
          // BlockOut already shows the new result while Done is high.
          l_q         <= l_q ^ PSub;
          block_out_q <= {l_q ^ PSub, r_q};
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (driven from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    PIdx    = '0;
    FEnable = 1'b0;
    FX      = '0;
    Done    = 1'b0;
    unique case (state_q)
      S_KEY: begin
        PIdx = sub_idx(dec_q, {1'b0, rnd_q});
      end
      S_FCALL: begin
        PIdx    = sub_idx(dec_q, {1'b0, rnd_q});
        FEnable = 1'b1;
        FX      = l_q;
      end
      S_WHT_R: PIdx = sub_idx(dec_q, 5'd16);
      S_WHT_L: PIdx = sub_idx(dec_q, 5'd17);
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Busy     = (state_q != S_IDLE);
  assign Error    = timeout;
  assign BlockOut = block_out_q;

endmodule

// File: doc/blowfish128_round_ctrl.md
# blowfish128_round_ctrl

Round sequencer for the Blowfish-128 cipher core. It accepts one 128-bit block and walks it through 16 Feistel rounds plus final whitening. Each round it reads one 64-bit P-array subkey through an external read port and invokes the shared F-function block through its Enable/outputValid handshake. It sits between the top-level cipher wrapper and the F-function instance; one controller owns one F-function.

## Interface
- TIMEOUT_CYCLES, 32: watchdog limit in cycles per F-function call. Used only when the watchdog is compiled in.
- Clk  input  1  clock; all state updates on its rising edge.
- RstN  input  1  reset; one clock, asynchronous assertion, active-low.
- Start  input  1  request to process BlockIn; sampled only in IDLE.
- Decrypt  input  1  0 = encrypt, 1 = decrypt; sampled together with Start.
- BlockIn  input  128  plaintext or ciphertext; [127:64] = L, [63:0] = R.
- PIdx  output  5  P-array read index, 0..17.
- PSub  input  64  P-array entry at PIdx; combinational read, valid in the same cycle.
- FEnable  output  1  drives the F-function Enable input; its low level resets the F-function.
- FX  output  64  F-function input X.
- FY  input  64  F-function output Y.
- FValid  input  1  F-function outputValid.
- BlockOut  output  128  result {L,R}; holds its value until the next Done.
- Done  output  1  one-cycle pulse; BlockOut is updated in the same cycle.
- Busy  output  1  high in every state except IDLE.
- Error  output  1  one-cycle watchdog abort pulse; tied 0 when the watchdog is compiled out.

## Operation
- Registers:
  - L and R, 64 bits each.
  - Round counter rnd, 4 bits.
  - Mode bit dec.
- Subkey index for step k is k when encrypting and 17-k when decrypting. PIdx is driven from the registered state only, never from inputs.
- IDLE:
  - Start=1 loads L=BlockIn[127:64], R=BlockIn[63:0], dec=Decrypt, rnd=0.
  - Next state is KEY.
- KEY:
  - PIdx=idx(rnd); L <= L ^ PSub; FEnable=0.
  - Next state is FCALL.
- FCALL:
  - FEnable=1; FX=L (registered, stable for the whole call); PIdx=idx(rnd).
  - Stays in FCALL until FValid=1.
  - On FValid with rnd<15: L <= R ^ FY, R <= L (swap), rnd++, next state KEY.
  - On FValid with rnd==15: R <= R ^ FY with no swap, next state WHT_R.
- WHT_R: PIdx=idx(16); R <= R ^ PSub.
- WHT_L: PIdx=idx(17); L <= L ^ PSub.
- DONE: BlockOut <= {L,R}; Done=1; next state IDLE.
- FValid is ignored outside FCALL.
- Start is ignored in every state except IDLE, including DONE. No request queueing.
- When idle, PIdx=0 and FX=0.
- All 32-bit and 64-bit operations are XOR only. No additions are performed in this block.

## Timing
- Reset values:
  - State = IDLE.
  - L, R, rnd, BlockOut = 0.
  - FEnable, Done, Busy, Error, PIdx, FX = 0.
- Reset mid-operation: immediate return to IDLE. FEnable dropping also resets the F-function. No Done is produced.
- FEnable is low for exactly one cycle (KEY) between consecutive F calls. This guarantees the F-function restarts from its idle state every round.
- Let k be the number of FCALL cycles up to and including the cycle in which FValid is sampled high. One round then costs 1+k cycles.
- Start is accepted at edge 0.
- Done is high during cycle 16·(1+k)+3 after edge 0. For k=6 that is cycle 115.
- Busy rises the cycle after Start is accepted and falls the cycle after Done.

## Configuration
- BLOWFISH128_ROUND_TIMEOUT_EN defined:
  - A counter runs during FCALL and is cleared on entry to FCALL.
  - If FValid has not arrived after TIMEOUT_CYCLES cycles, the controller drives Error=1 for one cycle and returns to IDLE.
  - FEnable drops and BlockOut is unchanged.
- BLOWFISH128_ROUND_TIMEOUT_EN undefined:
  - No counter is built and Error is constant 0.
  - FCALL waits indefinitely.

## Test plan
- Reset: hold RstN=0 → every output is 0 and Busy=0. Release and idle 10 cycles → outputs stay 0.
- Bench settings: P all zero; F model returns Y=0 with k=6. BlockIn=128'h0123456789ABCDEF_FEDCBA9876543210, encrypt → Done at cycle 115 and BlockOut=128'hFEDCBA9876543210_0123456789ABCDEF.
- Index order: encrypt → PIdx sequence over KEY/WHT states is 0,1,…,15,16,17. Decrypt → 17,16,…,2,1,0. FEnable is low in every KEY cycle.
- Round trip: random P, F model Y=X·3 mod 2^64 with random k in 1..8. Encrypt then decrypt 100 random blocks → original block recovered every time.
- Ignored requests: Start pulses during FCALL and in the DONE cycle → no restart and exactly one Done. A Start one cycle after Done is accepted. FValid pulses during KEY do not advance the round.
- Abort: RstN pulsed low mid-FCALL → immediate IDLE with no Done. With BLOWFISH128_ROUND_TIMEOUT_EN and FValid stuck at 0 → Error pulses 32 cycles into FCALL, Busy then drops, and BlockOut keeps its previous value.
